// File: rtl/tpu_pkg.sv
// ============================================================================
// Module : tpu_pkg
// Desc   : Shared width default and feeder state encoding for the TPU slice.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package tpu_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED0 = 2'd1,
    FEED1 = 2'd2,
    FEED2 = 2'd3
  } feeder_state_t;

endpackage

`default_nettype wire

// File: rtl/input_skew_feeder.sv
// ============================================================================
// Module : input_skew_feeder
// Desc   : Skews a 2x2 activation tile into the two systolic-array rows.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module input_skew_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] ub_in_00,
  input  logic [DATA_W-1:0] ub_in_01,
  input  logic [DATA_W-1:0] ub_in_10,
  input  logic [DATA_W-1:0] ub_in_11,
  input  logic              clear_err,
  output logic              ready,
  output logic [DATA_W-1:0] row0_data,
  output logic              row0_valid,
  output logic [DATA_W-1:0] row1_data,
  output logic              row1_valid,
  output logic              done,
  output logic              overrun
);

  feeder_state_t     state_q, state_d;

  // x00 goes straight into the row-0 output register on the load edge, so
  // only the three later words need holding.
  logic [DATA_W-1:0] x01_q, x01_d;
  logic [DATA_W-1:0] x10_q, x10_d;
  logic [DATA_W-1:0] x11_q, x11_d;

  logic [DATA_W-1:0] row0_data_q, row0_data_d;
  logic [DATA_W-1:0] row1_data_q, row1_data_d;
  logic              row0_valid_q, row0_valid_d;
  logic              row1_valid_q, row1_valid_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              overrun_q, overrun_d;

  always_comb begin
    state_d      = state_q;
    x01_d        = x01_q;
    x10_d        = x10_q;
    x11_d        = x11_q;
    row0_data_d  = '0;
    row1_data_d  = '0;
    row0_valid_d = 1'b0;
    row1_valid_d = 1'b0;
    done_d       = 1'b0;

    // A new overrun outranks a simultaneous clear.
    overrun_d = overrun_q;
    if (clear_err) begin
      overrun_d = 1'b0;
    end
    if (load_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          x01_d        = ub_in_01;
          x10_d        = ub_in_10;
          x11_d        = ub_in_11;
          row0_data_d  = ub_in_00;
          row0_valid_d = 1'b1;
          state_d      = FEED0;
        end
      end
      FEED0: begin
        row0_data_d  = x01_q;
        row0_valid_d = 1'b1;
        row1_data_d  = x10_q;
        row1_valid_d = 1'b1;
        state_d      = FEED1;
      end
      FEED1: begin
        row1_data_d  = x11_q;
        row1_valid_d = 1'b1;
        state_d      = FEED2;
      end
      FEED2: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      x01_q        <= '0;
      x10_q        <= '0;
      x11_q        <= '0;
      row0_data_q  <= '0;
      row1_data_q  <= '0;
      row0_valid_q <= 1'b0;
      row1_valid_q <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      x01_q        <= x01_d;
      x10_q        <= x10_d;
      x11_q        <= x11_d;
      row0_data_q  <= row0_data_d;
      row1_data_q  <= row1_data_d;
      row0_valid_q <= row0_valid_d;
      row1_valid_q <= row1_valid_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
      overrun_q    <= overrun_d;
    end
  end

  assign ready      = ready_q;
  assign row0_data  = row0_data_q;
  assign row0_valid = row0_valid_q;
  assign row1_data  = row1_data_q;
  assign row1_valid = row1_valid_q;
  assign done       = done_q;
  assign overrun    = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_input_skew_feeder.sv
// ============================================================================
// Module : tb_input_skew_feeder
// Desc   : Scoreboard bench for input_skew_feeder: directed tiles, then random loads.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_input_skew_feeder;
  import tpu_pkg::*;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_valid = 1'b0;
  logic          clear_err = 1'b0;
  logic [DW-1:0] ub_in_00 = '0;
  logic [DW-1:0] ub_in_01 = '0;
  logic [DW-1:0] ub_in_10 = '0;
  logic [DW-1:0] ub_in_11 = '0;
  logic          ready;
  logic [DW-1:0] row0_data;
  logic          row0_valid;
  logic [DW-1:0] row1_data;
  logic          row1_valid;
  logic          done;
  logic          overrun;

  always #5 clk = ~clk;

  input_skew_feeder #(.DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .ub_in_00   (ub_in_00),
    .ub_in_01   (ub_in_01),
    .ub_in_10   (ub_in_10),
    .ub_in_11   (ub_in_11),
    .clear_err  (clear_err),
    .ready      (ready),
    .row0_data  (row0_data),
    .row0_valid (row0_valid),
    .row1_data  (row1_data),
    .row1_valid (row1_valid),
    .done       (done),
    .overrun    (overrun)
  );

  typedef struct {
    int unsigned   cyc;
    logic          r0v;
    logic [DW-1:0] r0d;
    logic          r1v;
    logic [DW-1:0] r1d;
    logic          dn;
  } beat_t;

  typedef struct {
    int unsigned cyc;
    logic        rdy;
    logic        ovr;
  } stat_t;

  beat_t         bq[$];
  stat_t         sq[$];
  int unsigned   cyc = 0;
  int            n_checks = 0;
  int            n_pass = 0;
  bit            mon_en = 1'b0;
  int            m_busy = 0;      // edges left before the model accepts again
  bit            m_ovr = 1'b0;
  logic [DW-1:0] ub_mem [0:63];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drive one cycle of inputs and record what the coming edge must produce.
  task automatic step(input bit lv, input bit clr,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] c, input logic [DW-1:0] d);
    int unsigned n;
    @(posedge clk);
    #1;
    load_valid = lv;
    clear_err  = clr;
    ub_in_00   = a;
    ub_in_01   = b;
    ub_in_10   = c;
    ub_in_11   = d;
    n = cyc + 1;
    if (lv && m_busy != 0) m_ovr = 1'b1;
    else if (clr)          m_ovr = 1'b0;
    if (lv && m_busy == 0) begin
      bq.push_back('{n,     1'b1, a, 1'b0, DW'(0), 1'b0});
      bq.push_back('{n + 1, 1'b1, b, 1'b1, c,      1'b0});
      bq.push_back('{n + 2, 1'b0, DW'(0), 1'b1, d, 1'b0});
      bq.push_back('{n + 3, 1'b0, DW'(0), 1'b0, DW'(0), 1'b1});
      m_busy = 3;
    end else if (m_busy > 0) begin
      m_busy--;
    end
    sq.push_back('{n, (m_busy == 0), m_ovr});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  beat_t mon_bt;
  stat_t mon_st;

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (mon_en) begin
        while (sq.size() > 0 && sq[0].cyc < cyc) begin
          chk("status_order", DW'(sq[0].cyc), DW'(cyc));
          void'(sq.pop_front());
        end
        if (sq.size() > 0 && sq[0].cyc == cyc) begin
          mon_st = sq.pop_front();
          chk("ready", DW'(ready), DW'(mon_st.rdy));
          chk("overrun", DW'(overrun), DW'(mon_st.ovr));
        end
        while (bq.size() > 0 && bq[0].cyc < cyc) begin
          chk("missing_beat", DW'(bq[0].cyc), DW'(cyc));
          void'(bq.pop_front());
        end
        if (row0_valid || row1_valid || done) begin
          if (bq.size() > 0 && bq[0].cyc == cyc) begin
            mon_bt = bq.pop_front();
            chk("row0_valid", DW'(row0_valid), DW'(mon_bt.r0v));
            chk("row0_data", row0_data, mon_bt.r0d);
            chk("row1_valid", DW'(row1_valid), DW'(mon_bt.r1v));
            chk("row1_data", row1_data, mon_bt.r1d);
            chk("done", DW'(done), DW'(mon_bt.dn));
          end else begin
            chk("unexpected_output", DW'({row0_valid, row1_valid, done}), DW'(0));
          end
        end else begin
          chk("idle_padding", row0_data | row1_data, DW'(0));
          if (bq.size() > 0 && bq[0].cyc == cyc) begin
            chk("absent_beat", DW'(0), DW'(1));
            void'(bq.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ub_mem[i] = $urandom;
    ub_mem[8]  = 32'hFFFF_FFFF;
    ub_mem[9]  = 32'h8000_0000;
    ub_mem[10] = 32'h0000_0000;
    ub_mem[11] = 32'h0000_0001;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_ready", DW'(ready), DW'(1));
    chk("rst_row0_valid", DW'(row0_valid), DW'(0));
    chk("rst_row1_valid", DW'(row1_valid), DW'(0));
    chk("rst_row0_data", row0_data, DW'(0));
    chk("rst_row1_data", row1_data, DW'(0));
    chk("rst_done", DW'(done), DW'(0));
    chk("rst_overrun", DW'(overrun), DW'(0));
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Single tile, then a second tile the cycle ready returns.
    step(1'b1, 1'b0, 11, 12, 21, 22);
    repeat (3) idle();
    step(1'b1, 1'b0, 5, 6, 7, 8);
    repeat (3) idle();

    // Load attempt during FEED1, then clear.
    step(1'b1, 1'b0, 31, 32, 33, 34);
    idle();
    step(1'b1, 1'b0, 99, 99, 99, 99);
    repeat (3) idle();
    step(1'b0, 1'b1, 0, 0, 0, 0);
    idle();

    // Clear and new overrun on the same edge: overrun must remain set.
    step(1'b1, 1'b0, 41, 42, 43, 44);
    step(1'b1, 1'b1, 55, 55, 55, 55);
    repeat (2) idle();
    step(1'b0, 1'b1, 0, 0, 0, 0);

    // Extreme values, then a load in the cycle the FSM leaves FEED2.
    step(1'b1, 1'b0, ub_mem[8], ub_mem[9], ub_mem[10], ub_mem[11]);
    repeat (2) idle();
    step(1'b1, 1'b0, 77, 77, 77, 77);
    idle();
    step(1'b0, 1'b1, 0, 0, 0, 0);

    // Asynchronous reset while the tile is in FEED1.
    step(1'b1, 1'b0, 1, 2, 3, 4);
    idle();
    @(posedge clk);
    @(negedge clk);
    #1;
    mon_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("async_row0_valid", DW'(row0_valid), DW'(0));
    chk("async_row1_valid", DW'(row1_valid), DW'(0));
    chk("async_row0_data", row0_data, DW'(0));
    chk("async_row1_data", row1_data, DW'(0));
    chk("async_done", DW'(done), DW'(0));
    chk("async_ready", DW'(ready), DW'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    bq.delete();
    sq.delete();
    m_busy = 0;
    m_ovr  = 1'b0;
    reset  = 1'b0;
    #1;
    chk("post_reset_ready", DW'(ready), DW'(1));
    mon_en = 1'b1;

    // Random tiles read from the buffer image at random word addresses.
    for (int k = 0; k < 400; k++) begin
      int unsigned addr;
      addr = $urandom_range(0, 60);
      step(($urandom_range(0, 9) < 4), ($urandom_range(0, 15) == 0),
           ub_mem[addr], ub_mem[addr + 1], ub_mem[addr + 2], ub_mem[addr + 3]);
    end
    repeat (6) idle();
    @(posedge clk);
    #3;
    chk("queues_drained", DW'(bq.size() + sq.size()), DW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
